disp_arbiter: RTL and testbench
===============================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, 8, minimum ownership cycles before preemption (SHALL be >= 2).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req  input  3  per-requester display request, level, bit i = requester i.
REQ-005 upd  input  3  per-requester update strobe, 1-cycle pulse, meaningful only for current owner.
REQ-006 data0, data1, data2  input  16 each  requester value, nibble [3:0] = rightmost digit.
REQ-007 gnt  output  3  one-hot grant, all-zero when no owner, registered.
REQ-008 hex0..hex3  output  4 each  digit nibbles to scan driver (hex0 = data[3:0] ... hex3 = data[15:12]), registered.
REQ-009 disp_en  output  1  high when hex0..hex3 carry owner data; low = display blank.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, OWN, GAP.
- IDLE: gnt=0, disp_en=0, hex0..hex3=0.
- OWN: gnt one-hot = owner, disp_en=1.
- GAP: gnt=0, disp_en=0, hex0..hex3 hold their last values.
REQ-011 IDLE -> OWN on the first edge where any req bit is 1; the winner SHALL be selected round-robin, starting at (last_owner+1) mod 3.
REQ-012 On entry to OWN, gnt, hex0..hex3 (from data of the winner) and disp_en SHALL all update on the same edge, one cycle after req is sampled.
REQ-013 In OWN, upd[owner]=1 SHALL load data of the owner into hex0..hex3 on the next edge; upd bits of non-owners SHALL be ignored.
REQ-014 A hold counter SHALL clear on OWN entry, increment each OWN cycle, and saturate at HOLD_CYCLES-1; width = ceil(log2(HOLD_CYCLES)).
REQ-015 OWN -> GAP when the owner's req drops while any other req is high, or when counter = HOLD_CYCLES-1 and any other req is high (preemption).
REQ-016 OWN -> IDLE when the owner's req drops and no other req is high.
REQ-017 If counter is saturated and no other req is high, the owner SHALL keep the grant indefinitely.
REQ-018 GAP SHALL last exactly one cycle, then go to OWN with the round-robin winner among currently high req bits; if none are high, go to IDLE.
REQ-019 The last_owner pointer SHALL update on every OWN entry.
REQ-020 Simultaneous owner-release and counter expiry SHALL be handled as a release (REQ-015 and REQ-016 apply).
REQ-021 A requester whose req is low at the arbitration edge SHALL NOT be granted, even if it was asserted earlier.
REQ-022 gnt SHALL never have more than one bit set.

Reset
REQ-023 On reset assertion, the block SHALL immediately force the following, regardless of state or counter value:
- state = IDLE
- gnt = 0, hex0..hex3 = 0, disp_en = 0
- hold counter = 0
- last_owner = 2, so requester 0 has first priority.
REQ-024 After reset deasserts, the first grant SHALL follow REQ-011 with no extra latency.

Structure
REQ-025 A shared package SHALL hold:
- the state enumeration (IDLE, OWN, GAP)
- constant NUM_REQ = 3
- the 2-bit owner-index type.
REQ-026 The round-robin selection SHALL be a combinational sub-module named disp_rr_pick with:
- inputs: req vector, last_owner
- outputs: found flag, winner index.
REQ-027 Output registers SHALL feed the existing 4-digit scan display driver directly, with no combinational path from req or data to the outputs.

Verification (HOLD_CYCLES=8)
REQ-028 Reset release, req=001, data0=0x1234 -> one cycle later gnt=001, disp_en=1, hex3..hex0 = 1,2,3,4.
REQ-029 Owner 0 active, data0 changed to 0xBEEF, upd=001 -> next cycle hex = B,E,E,F; upd=010 with data1=0x5555 -> hex unchanged.
REQ-030 req=011 from IDLE -> gnt=001 for 8 cycles, then 1 GAP cycle (gnt=000, disp_en=0), then gnt=010 with hex = data1.
REQ-031 Owner 1 active, req drops to 000 -> next cycle IDLE, gnt=000, hex=0000; then req=101 -> gnt=100 (pointer after 1 is 2).
REQ-032 Owner 0 at counter=7, req[0] drops while req[2] rises on the same edge -> one GAP cycle, then gnt=100.
REQ-033 Reset pulse mid-OWN (counter=4) -> gnt=000, hex=0000, disp_en=0 immediately; with req=111 after release -> gnt=001.

Source files
------------

// File: rtl/disp_arbiter_pkg.sv
// rtl/disp_arbiter_pkg.sv - shared types and constants for the display arbiter
package disp_arbiter_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef logic [1:0] owner_t;

endpackage

// File: rtl/disp_rr_pick.sv
// rtl/disp_rr_pick.sv - combinational round-robin winner selection
module disp_rr_pick
  import disp_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  owner_t             last_owner,
  output logic               found,
  output owner_t             winner
);

  // scan requesters starting just after the previous owner, first high bit wins
  always_comb begin
    int c;
    found  = 1'b0;
    winner = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(last_owner) + k) % NUM_REQ;
      if (!found && req[c]) begin
        found  = 1'b1;
        winner = owner_t'(c);
      end
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - round-robin display ownership arbiter with hold/preempt timer
module disp_arbiter
  import disp_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  upd,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  gnt,
  output logic [3:0]  hex0,
  output logic [3:0]  hex1,
  output logic [3:0]  hex2,
  output logic [3:0]  hex3,
  output logic        disp_en
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

  state_t        state;
  owner_t        last_owner;   // equals the current owner while in OWN
  logic [CW-1:0] cnt;

  logic          found;
  owner_t        winner;
  logic [15:0]   win_data;
  logic [15:0]   own_data;
  logic [2:0]    own_mask;
  logic          owner_req;
  logic          others;

  disp_rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner),
    .found      (found),
    .winner     (winner)
  );

  // data muxes for the arbitration winner and for the current owner
  always_comb begin
    win_data = data0;
    own_data = data0;
    case (winner)
      2'd1:    win_data = data1;
      2'd2:    win_data = data2;
      default: win_data = data0;
    endcase
    case (last_owner)
      2'd1:    own_data = data1;
      2'd2:    own_data = data2;
      default: own_data = data0;
    endcase
  end

  // owner request and competing-request detection
  always_comb begin
    own_mask  = 3'b001 << last_owner;
    owner_req = |(req & own_mask);
    others    = |(req & ~own_mask);
  end

  // arbitration FSM with registered grant and display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                    <= IDLE;
      last_owner               <= 2'd2;
      cnt                      <= '0;
      gnt                      <= 3'b000;
      disp_en                  <= 1'b0;
      {hex3, hex2, hex1, hex0} <= 16'h0000;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (found) begin
            state                    <= OWN;
            last_owner               <= winner;
            cnt                      <= '0;
            gnt                      <= 3'b001 << winner;
            disp_en                  <= 1'b1;
            {hex3, hex2, hex1, hex0} <= win_data;
          end else begin
            state                    <= IDLE;
            gnt                      <= 3'b000;
            disp_en                  <= 1'b0;
            {hex3, hex2, hex1, hex0} <= 16'h0000;
          end
        end
        OWN: begin
          if (!owner_req) begin
            // release wins over expiry when both happen together
            gnt     <= 3'b000;
            disp_en <= 1'b0;
            if (others) begin
              state <= GAP;
            end else begin
              state                    <= IDLE;
              {hex3, hex2, hex1, hex0} <= 16'h0000;
            end
          end else if (cnt == CNT_MAX && others) begin
            state   <= GAP;
            gnt     <= 3'b000;
            disp_en <= 1'b0;
          end else begin
            if (upd[last_owner]) begin
              {hex3, hex2, hex1, hex0} <= own_data;
            end
            if (cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          gnt     <= 3'b000;
          disp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb/tb_disp_arbiter.sv - self-checking bench for disp_arbiter against a behavioural model
module tb_disp_arbiter;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [2:0]  upd = 3'b000;
  logic [15:0] data0 = 16'h0000;
  logic [15:0] data1 = 16'h0000;
  logic [15:0] data2 = 16'h0000;
  logic [2:0]  gnt;
  logic [3:0]  hex0, hex1, hex2, hex3;
  logic        disp_en;

  int checks = 0;
  int errors = 0;

  // model: who owns the display (-1 = nobody), whether we sit in the gap cycle
  int          m_owner;
  bit          m_gap;
  int          m_last;
  int          m_held;
  logic [15:0] m_hex;

  disp_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .upd     (upd),
    .data0   (data0),
    .data1   (data1),
    .data2   (data2),
    .gnt     (gnt),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .disp_en (disp_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dsel(input int i);
    return (i == 0) ? data0 : (i == 1) ? data1 : data2;
  endfunction

  // who is next in line after the last owner among the currently asserted requests
  function automatic int rr_next(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_last = 2; m_held = 0; m_hex = 16'h0000;
  endtask

  task automatic model_edge();
    int w;
    bit rivals;
    if (m_owner < 0) begin
      w = rr_next(req, m_last);
      m_gap = 0;
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 0; m_hex = dsel(w);
      end else begin
        m_hex = 16'h0000;
      end
    end else begin
      rivals = (req & ~(3'b001 << m_owner)) != 3'b000;
      if (!req[m_owner] || (m_held >= HOLD - 1 && rivals)) begin
        m_owner = -1;
        m_gap = rivals;
        if (!rivals) m_hex = 16'h0000;
      end else begin
        if (upd[m_owner]) m_hex = dsel(m_owner);
        m_held++;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".gnt"}, 16'(gnt), (m_owner < 0) ? 16'h0 : 16'(3'b001 << m_owner));
    check({tag, ".en"}, 16'(disp_en), 16'(m_owner >= 0));
    check({tag, ".hex"}, {hex3, hex2, hex1, hex0}, m_hex);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check({tag, ".rst_gnt"}, 16'(gnt), 16'h0);
    check({tag, ".rst_en"}, 16'(disp_en), 16'h0);
    check({tag, ".rst_hex"}, {hex3, hex2, hex1, hex0}, 16'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset("init");

    // first grant straight after reset
    req = 3'b001; data0 = 16'h1234;
    step("r028");
    check("r028.gnt", 16'(gnt), 16'h0001);
    check("r028.hex", {hex3, hex2, hex1, hex0}, 16'h1234);

    // owner update strobe, then a non-owner strobe that must be ignored
    data0 = 16'hBEEF; upd = 3'b001;
    step("r029a");
    check("r029.upd", {hex3, hex2, hex1, hex0}, 16'hBEEF);
    upd = 3'b010; data1 = 16'h5555;
    step("r029b");
    check("r029.ign", {hex3, hex2, hex1, hex0}, 16'hBEEF);
    upd = 3'b000;

    // hold then preempt with a one-cycle gap
    do_reset("r030");
    req = 3'b011; data0 = 16'h0A0A;
    for (int i = 0; i < HOLD; i++) begin
      step("r030own");
      check("r030.gnt0", 16'(gnt), 16'h0001);
    end
    step("r030gap");
    check("r030.gap", 16'(gnt), 16'h0000);
    check("r030.gap_en", 16'(disp_en), 16'h0000);
    step("r030next");
    check("r030.gnt1", 16'(gnt), 16'h0002);
    check("r030.hex1", {hex3, hex2, hex1, hex0}, 16'h5555);

    // release to idle, then pointer continues past owner 1
    req = 3'b000;
    step("r031idle");
    check("r031.hex0", {hex3, hex2, hex1, hex0}, 16'h0000);
    req = 3'b101; data2 = 16'hC0DE;
    step("r031grant");
    check("r031.gnt2", 16'(gnt), 16'h0004);

    // owner 0 at full count releases as requester 2 rises
    req = 3'b001;
    step("r032a");
    step("r032b");
    check("r032.own0", 16'(gnt), 16'h0001);
    for (int i = 0; i < HOLD - 1; i++) step("r032hold");
    req = 3'b100;
    step("r032gap");
    check("r032.gap", 16'(gnt), 16'h0000);
    step("r032grant");
    check("r032.gnt2", 16'(gnt), 16'h0004);

    // reset in the middle of ownership
    do_reset("r033pre");
    req = 3'b001;
    step("r033own");
    for (int i = 0; i < 4; i++) step("r033hold");
    do_reset("r033");
    req = 3'b111;
    step("r033grant");
    check("r033.gnt0", 16'(gnt), 16'h0001);

    // randomized traffic, sticky requests so ownership lasts a while
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom);
      upd   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      data0 = 16'($urandom);
      data1 = 16'($urandom);
      data2 = 16'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd");
      end else begin
        step("rnd");
        checks++;
        assert (!(gnt & (gnt - 3'b001))) else begin
          errors++;
          $error("FAIL onehot observed=%b expected=at_most_one_bit", gnt);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
